// File: rtl/seq_square_pkg.sv
// Shared widths, state encoding and the shift-add step for seq_square_check.
package seq_square_pkg;

  localparam int ROOT_W = 8;
  localparam int SQ_W   = 16;
  localparam int REM_W  = 9;
  localparam int ITER   = 8;
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // One MSB-first shift-add multiply step; acc never exceeds 255*255.
  function automatic logic [SQ_W-1:0] sq_step(input logic [SQ_W-1:0]   acc,
                                               input logic [ROOT_W-1:0] root,
                                               input logic              root_bit);
    logic [SQ_W-1:0] addend;
    addend  = root_bit ? {{(SQ_W-ROOT_W){1'b0}}, root} : '0;
    sq_step = {acc[SQ_W-2:0], 1'b0} + addend;
  endfunction

endpackage

// File: rtl/sq_acc_reg.sv
// Accumulator register for the sequential squarer: load-enable, async active-low clear.
module sq_acc_reg
  import seq_square_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [SQ_W-1:0] d,
  output logic [SQ_W-1:0] q
);

  logic [SQ_W-1:0] acc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= d;
    end
  end

  assign q = acc_q;

endmodule

// File: rtl/seq_square_check.sv
// Sequential root*root squarer with optional floor-sqrt check (macro SEQ_SQUARE_CHECK_EN).
// Without the macro, remainder and ok are tied low and the radicand is not stored.
module seq_square_check
  import seq_square_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [ROOT_W-1:0] root,
  input  logic [SQ_W-1:0]   radicand,
  output logic              busy,
  output logic              done,
  output logic [SQ_W-1:0]   square,
  output logic [REM_W-1:0]  remainder,
  output logic              ok
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [SQ_W-1:0]   square_q, square_d;
  logic              done_q, done_d;
  logic [SQ_W-1:0]   acc_q, acc_d;
  logic              acc_en;
  logic [SQ_W-1:0]   step_acc;
  logic [CNT_W-1:0]  bit_idx;
  logic              last_step;

`ifdef SEQ_SQUARE_CHECK_EN
  logic [SQ_W-1:0]   radicand_q, radicand_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              ok_q, ok_d;
  logic [SQ_W:0]     diff;
`else
  logic              unused_radicand;
  assign unused_radicand = ^radicand;
`endif

  sq_acc_reg u_acc (
    .clock (clock),
    .reset (reset),
    .en    (acc_en),
    .d     (acc_d),
    .q     (acc_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        IDLE:    if (start) state_d = CALC;
        CALC:    if (last_step) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Root bits are consumed MSB-first, so the counter maps to bit 7 down to 0.
  assign bit_idx   = CNT_W'(ROOT_W - 1) - cnt_q;
  assign last_step = (cnt_q == CNT_W'(ITER - 1));
  assign step_acc  = sq_step(acc_q, root_q, root_q[bit_idx]);

`ifdef SEQ_SQUARE_CHECK_EN
  assign diff = {1'b0, radicand_q} - {1'b0, step_acc};
`endif

  always_comb begin
    cnt_d    = cnt_q;
    root_d   = root_q;
    square_d = square_q;
    done_d   = done_q;
    acc_d    = acc_q;
    acc_en   = 1'b0;
`ifdef SEQ_SQUARE_CHECK_EN
    radicand_d = radicand_q;
    rem_d      = rem_q;
    ok_d       = ok_q;
`endif
    if (enable) begin
      done_d = 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          root_d = root;
          cnt_d  = '0;
          acc_d  = '0;
          acc_en = 1'b1;
`ifdef SEQ_SQUARE_CHECK_EN
          radicand_d = radicand;
`endif
        end
      end else begin
        acc_d  = step_acc;
        acc_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_step) begin
          square_d = step_acc;
          done_d   = 1'b1;
`ifdef SEQ_SQUARE_CHECK_EN
          rem_d = diff[REM_W-1:0];
          // Exact floor root: no borrow and the leftover is at most 2*root.
          ok_d  = !diff[SQ_W] &&
                  (diff[SQ_W-1:0] <= {{(SQ_W-ROOT_W-1){1'b0}}, root_q, 1'b0});
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      root_q   <= '0;
      square_q <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_SQUARE_CHECK_EN
      radicand_q <= '0;
      rem_q      <= '0;
      ok_q       <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      square_q <= square_d;
      done_q   <= done_d;
`ifdef SEQ_SQUARE_CHECK_EN
      radicand_q <= radicand_d;
      rem_q      <= rem_d;
      ok_q       <= ok_d;
`endif
    end
  end

  always_comb begin
    busy   = (state_q == CALC);
    done   = done_q;
    square = square_q;
`ifdef SEQ_SQUARE_CHECK_EN
    remainder = rem_q;
    ok        = ok_q;
`else
    remainder = '0;
    ok        = 1'b0;
`endif
  end

endmodule

// File: doc/seq_square_check.md
SEQ_SQUARE_CHECK -- requirements
Module: seq_square_check

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: enable  in  1  clock enable; when 0, all state and outputs hold.
REQ-004 SHALL have port: start  in  1  request; sampled only in IDLE with enable=1.
REQ-005 SHALL have port: root  in  8  candidate root from the square-root pipeline; captured on start.
REQ-006 SHALL have port: radicand  in  16  original operand; captured on start.
REQ-007 SHALL have port: busy  out  1  high while in CALC.
REQ-008 SHALL have port: done  out  1  one-cycle pulse; results valid from this cycle.
REQ-009 SHALL have port: square  out  16  root*root, held until next start.
REQ-010 SHALL have port: remainder  out  9  radicand - square (check feature only).
REQ-011 SHALL have port: ok  out  1  root is the exact floor square root of radicand (check feature only).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and CALC.
REQ-013 IDLE -> CALC SHALL occur when start=1 and enable=1; root and radicand SHALL be latched, accumulator cleared, 3-bit counter set to 0.
REQ-014 CALC SHALL perform one shift-add step per enabled cycle, using root bits MSB-first: acc = (acc<<1) + (bit ? root : 0), 16-bit, no overflow possible.
REQ-015 CALC -> IDLE SHALL occur on the enabled edge where counter=7; on that edge square, remainder and ok SHALL update and done SHALL go high.
REQ-016 Latency SHALL be exactly 8 enabled cycles from the start-sampling edge to the edge that raises done.
REQ-017 done SHALL fall on the next enabled edge; when enable=0, done SHALL hold its value.
REQ-018 start while busy SHALL be ignored, with no queuing.
REQ-019 start in the same cycle that done is high SHALL be accepted, giving back-to-back operation.
REQ-020 enable=0 mid-CALC SHALL freeze counter, accumulator and state, with no lost or repeated step.
REQ-021 Boundaries: root=0 SHALL give square=0; root=255 SHALL give square=65025.

Reset
REQ-022 reset=0 SHALL force, asynchronously: state=IDLE, busy=0, done=0, square=0, remainder=0, ok=0, counter=0, accumulator=0.
REQ-023 reset mid-CALC SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-024 The first start SHALL be accepted on the first enabled edge after reset release.

Configuration
REQ-025 Macro SEQ_SQUARE_CHECK_EN defined: on done, remainder = radicand - square (low 9 bits).
REQ-026 With SEQ_SQUARE_CHECK_EN defined, on done: ok=1 iff square <= radicand and radicand - square <= 2*root.
REQ-027 Macro SEQ_SQUARE_CHECK_EN undefined: the radicand latch and compare logic SHALL be absent; remainder and ok SHALL be tied 0; ports SHALL remain present.

Structure
REQ-028 Package seq_square_pkg SHALL hold ROOT_W=8, SQ_W=16, REM_W=9, ITER=8 and the state enum (IDLE, CALC).
REQ-029 One sub-module sq_acc_reg (16-bit register with enable, async active-low clear) SHALL hold the accumulator; the FSM and counter SHALL stay in the top level.

Verification
REQ-030 root=12, radicand=150, start one cycle -> done 8 cycles later, square=144, remainder=6, ok=1.
REQ-031 root=13, radicand=150 -> square=169, ok=0; root=11, radicand=150 -> square=121, remainder=29 (>22), ok=0.
REQ-032 root=255, radicand=65535 -> square=65025, remainder=510, ok=1; root=0, radicand=0 -> square=0, ok=1.
REQ-033 enable=0 for 3 cycles mid-CALC -> done at 11 cycles; start re-pulsed while busy -> no effect; start asserted on the done cycle -> second result after 8 further cycles.
REQ-034 reset=0 at the 4th CALC cycle -> all outputs 0 immediately; no done after release; then root=7 -> square=49.
REQ-035 Build without SEQ_SQUARE_CHECK_EN -> remainder=0 and ok=0 always; square and latency unchanged.
